// File: rtl/w0rm_peripheral_bus_response_queue.sv
// w0rm peripheral bus response queue
// Small response FIFO that holds each word on the bus until the extender takes it
module w0rm_peripheral_bus_response_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  bus_clock,
  input  logic                  bus_reset_n,
  input  logic                  resp_valid_i,
  input  logic [DATA_WIDTH-1:0] resp_data_i,
  output logic                  resp_ready_o,
  input  logic                  bus_yield_i,
  output logic                  bus_valid_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  ptr_t wr_ptr_nxt;
  ptr_t rd_ptr_nxt;
  cnt_t count;
  cnt_t count_nxt;
  cnt_t count_held;

  logic push;
  logic pop;
  logic drop;
  logic valid_nxt;
  logic ovf_nxt;

  logic [DATA_WIDTH-1:0] head_nxt;

  // Ready depends on registered occupancy only.
  assign resp_ready_o = (count < FULL);
  assign push         = resp_valid_i & resp_ready_o;
  assign drop         = resp_valid_i & ~resp_ready_o;
  assign pop          = bus_valid_o & ~bus_yield_i;
  assign count_o      = count;

  // Pointer advance on push and delivery.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (push) wr_ptr_nxt = wr_ptr + ptr_t'(1);
    if (pop)  rd_ptr_nxt = rd_ptr + ptr_t'(1);
  end

  // Occupancy update; push and delivery together leave it unchanged.
  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      (push & ~pop): count_nxt = count + cnt_t'(1);
      (pop & ~push): count_nxt = count - cnt_t'(1);
      default:       count_nxt = count;
    endcase
  end

  // Words left in storage after this cycle's delivery, before any push.
  always_comb begin
    count_held = count - cnt_t'(pop);
  end

  // Next head word, bypassing storage when the pushed word becomes the head.
  always_comb begin
    head_nxt  = '0;
    valid_nxt = (count_nxt != '0);
    if (!valid_nxt) begin
      head_nxt = '0;
    end else if (count_held == '0) begin
      head_nxt = resp_data_i;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Sticky overflow on a word offered while full.
  always_comb begin
    ovf_nxt = overflow_o | drop;
  end

  // Storage write; contents need no reset.
  always_ff @(posedge bus_clock) begin
    if (push) mem[wr_ptr] <= resp_data_i;
  end

  // Pointer and occupancy state.
  always_ff @(posedge bus_clock) begin
    if (!bus_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Registered bus presentation and overflow flag.
  always_ff @(posedge bus_clock) begin
    if (!bus_reset_n) begin
      bus_valid_o <= 1'b0;
      bus_data_o  <= '0;
      overflow_o  <= 1'b0;
    end else begin
      bus_valid_o <= valid_nxt;
      bus_data_o  <= head_nxt;
      overflow_o  <= ovf_nxt;
    end
  end

endmodule
